// File: rtl/in_dev_ctrl_pkg.sv
// Shared definitions for the CPU input peripheral: register select codes,
// bus base addresses, interrupt line index and small decode helpers.
package in_dev_ctrl_pkg;

    typedef enum logic [1:0] {
        IN_SEL_SW   = 2'b00,
        IN_SEL_BTN  = 2'b01,
        IN_SEL_EVT  = 2'b10,
        IN_SEL_MASK = 2'b11
    } in_sel_e;

    localparam logic [31:0] OUT_DEV_BASE   = 32'h0000_7f10;
    localparam logic [31:0] IN_DEV_BASE    = 32'h0000_7f20;
    localparam int unsigned IN_DEV_IRQ_IDX = 32'd2;

    // A bus write that targets one specific register.
    function automatic logic is_wr(input logic we, input logic [1:0] sel, input in_sel_e code);
        return we && (sel == code);
    endfunction

endpackage

// File: rtl/in_dev_ctrl_debounce.sv
// One button bit: two-flop synchroniser, stability counter and accepted level,
// plus a pulse on the same edge the accepted level rises.
module in_debounce #(
    parameter int DB_CYCLES = 50000,
    parameter int DB_W      = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            stable_q, stable_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // State register for synchroniser, counter and accepted level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Any cycle where the synchronised input agrees with the accepted level restarts the count.
    always_comb begin
        sync1_d  = din;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + DB_W'(1);
        end
    end

    // Outputs: accepted level and its rising-edge pulse aligned to the update edge.
    always_comb begin
        level = stable_q;
        rise  = stable_d & ~stable_q;
    end

endmodule

// File: rtl/in_dev_ctrl.sv
// CPU-readable input peripheral: synchronised switches, debounced buttons,
// write-one-to-clear press events, interrupt mask and a registered irq.
module in_dev_ctrl
    import in_dev_ctrl_pkg::*;
#(
    parameter int NBTN      = 4,
    parameter int DB_CYCLES = 50000,
    parameter int DB_W      = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [1:0]      sel,
    input  logic [31:0]     in,
    output logic [31:0]     out,
    input  logic [31:0]     sw,
    input  logic [NBTN-1:0] btn,
    output logic            irq
);

    logic [31:0]     sw_sync1_q, sw_sync1_d;
    logic [31:0]     sw_sync2_q, sw_sync2_d;
    logic [NBTN-1:0] evt_q, evt_d;
    logic [NBTN-1:0] mask_q, mask_d;
    logic            irq_q, irq_d;

    logic [NBTN-1:0] stable_s;
    logic [NBTN-1:0] rise_s;
    logic [31:0]     out_s;
    logic            unused_in_s;

    // Only the low NBTN bits of the write data reach EVT/MASK.
    assign unused_in_s = ^in;

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        in_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .DB_W      (DB_W)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .din   (btn[i]),
            .level (stable_s[i]),
            .rise  (rise_s[i])
        );
    end

    // State register for switch synchroniser, event/mask registers and irq.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_sync1_q <= 32'd0;
            sw_sync2_q <= 32'd0;
            evt_q      <= '0;
            mask_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            sw_sync1_q <= sw_sync1_d;
            sw_sync2_q <= sw_sync2_d;
            evt_q      <= evt_d;
            mask_q     <= mask_d;
            irq_q      <= irq_d;
        end
    end

    // Next-state: a press arriving on the clearing cycle survives the clear.
    always_comb begin
        sw_sync1_d = sw;
        sw_sync2_d = sw_sync1_q;
        if (is_wr(we, sel, IN_SEL_EVT)) begin
            evt_d = (evt_q & ~in[NBTN-1:0]) | rise_s;
        end else begin
            evt_d = evt_q | rise_s;
        end
        if (is_wr(we, sel, IN_SEL_MASK)) begin
            mask_d = in[NBTN-1:0];
        end else begin
            mask_d = mask_q;
        end
        irq_d = |(evt_d & mask_d);
    end

    // Read mux; unused upper bits always read zero.
    always_comb begin
        out_s = 32'd0;
        case (sel)
            IN_SEL_SW:   out_s               = sw_sync2_q;
            IN_SEL_BTN:  out_s[NBTN-1:0]     = stable_s;
            IN_SEL_EVT:  out_s[NBTN-1:0]     = evt_q;
            IN_SEL_MASK: out_s[NBTN-1:0]     = mask_q;
            default:     out_s               = 32'd0;
        endcase
    end

    assign out = out_s;
    assign irq = irq_q;

endmodule
